// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: serves image-RAM bytes to the HPS over the ioctl upload path.
// Keeps a one-byte prefetch of the next sequential address so that streaming reads
// complete in one cycle. Non-sequential or early requests are held off with ioctl_wait.
module ioctl_upload_reader #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned SIZE    = 16384,
  parameter int unsigned RAM_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [26:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              busy,
  output logic              done
);

  // One extra bit so a prefetch address equal to SIZE = 2^ADDR_W is representable.
  localparam int unsigned   PW    = ADDR_W + 1;
  localparam logic [PW-1:0] SizeP = PW'(SIZE);
  localparam logic [26:0]   SizeA = 27'(SIZE);
  localparam logic [2:0]    LatC  = 3'(RAM_LAT);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPrefetch = 2'd1;
  localparam logic [1:0] StReady    = 2'd2;
  localparam logic [1:0] StFetch    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [PW-1:0]     pf_addr_q, pf_addr_d;
  logic [7:0]        pf_data_q, pf_data_d;
  logic              pf_valid_q, pf_valid_d;
  logic              pend_q, pend_d;
  logic [26:0]       pend_addr_q, pend_addr_d;
  logic [PW-1:0]     fetch_addr_q, fetch_addr_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_rd_q, ram_rd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              upload_q;

  logic              resolve;
  logic [7:0]        cur_data;
  logic              cur_valid;
  logic [26:0]       req_addr;
  logic              new_req;
  logic [PW-1:0]     pf_next;
  logic [PW-1:0]     fetch_next;

  // A strobe while ioctl_wait is high violates the protocol and is dropped.
  assign new_req    = ioctl_rd && !wait_q;
  assign req_addr   = pend_q ? pend_addr_q : ioctl_addr;
  assign pf_next    = pf_addr_q + 1'b1;
  assign fetch_next = fetch_addr_q + 1'b1;

  // Next-state logic: sequencing, request resolution, session abort.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pf_addr_d    = pf_addr_q;
    pf_data_d    = pf_data_q;
    pf_valid_d   = pf_valid_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    fetch_addr_d = fetch_addr_q;
    din_d        = din_q;
    wait_d       = wait_q;
    ram_addr_d   = ram_addr_q;
    ram_rd_d     = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    resolve      = 1'b0;
    cur_data     = pf_data_q;
    cur_valid    = pf_valid_q;

    case (state_q)
      StIdle: begin
        if (ioctl_upload && !upload_q) begin
          ram_rd_d   = 1'b1;
          ram_addr_d = '0;
          pf_addr_d  = '0;
          pf_valid_d = 1'b0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = StPrefetch;
        end
      end
      StPrefetch: begin
        if (cnt_q == LatC) begin
          // Capture edge: a waiting or simultaneous request sees the fresh byte.
          cur_data   = ram_q;
          cur_valid  = 1'b1;
          pf_data_d  = ram_q;
          pf_valid_d = 1'b1;
          state_d    = StReady;
          resolve    = pend_q || new_req;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (new_req) begin
            pend_d      = 1'b1;
            pend_addr_d = ioctl_addr;
            wait_d      = 1'b1;
          end
        end
      end
      StReady: begin
        resolve = new_req;
      end
      StFetch: begin
        if (cnt_q == LatC) begin
          din_d  = ram_q;
          wait_d = 1'b0;
          if (fetch_next < SizeP) begin
            ram_rd_d   = 1'b1;
            ram_addr_d = fetch_next[ADDR_W-1:0];
            pf_addr_d  = fetch_next;
            pf_valid_d = 1'b0;
            cnt_d      = '0;
            state_d    = StPrefetch;
          end else begin
            pf_valid_d = 1'b0;
            state_d    = StReady;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (resolve) begin
      pend_d = 1'b0;
      if (req_addr >= SizeA) begin
        // Out of range: constant fill, RAM and prefetch untouched.
        din_d  = 8'hFF;
        wait_d = 1'b0;
      end else if (cur_valid && (req_addr == 27'(pf_addr_q))) begin
        din_d      = cur_data;
        wait_d     = 1'b0;
        pf_valid_d = 1'b0;
        if (pf_next < SizeP) begin
          ram_rd_d   = 1'b1;
          ram_addr_d = pf_next[ADDR_W-1:0];
          pf_addr_d  = pf_next;
          cnt_d      = '0;
          state_d    = StPrefetch;
        end else begin
          state_d = StReady;
        end
      end else begin
        wait_d       = 1'b1;
        ram_rd_d     = 1'b1;
        ram_addr_d   = req_addr[ADDR_W-1:0];
        fetch_addr_d = {1'b0, req_addr[ADDR_W-1:0]};
        pf_valid_d   = 1'b0;
        cnt_d        = '0;
        state_d      = StFetch;
      end
    end

    // Session end overrides everything; ioctl_din keeps its last value.
    if ((state_q != StIdle) && !ioctl_upload) begin
      state_d    = StIdle;
      cnt_d      = '0;
      pf_valid_d = 1'b0;
      pend_d     = 1'b0;
      din_d      = din_q;
      wait_d     = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_rd_d   = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pf_addr_q    <= '0;
      pf_data_q    <= '0;
      pf_valid_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      fetch_addr_q <= '0;
      din_q        <= '0;
      wait_q       <= 1'b0;
      ram_addr_q   <= '0;
      ram_rd_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      // Reset high so an upload still asserted at reset release is not seen as a rise.
      upload_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pf_addr_q    <= pf_addr_d;
      pf_data_q    <= pf_data_d;
      pf_valid_q   <= pf_valid_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      fetch_addr_q <= fetch_addr_d;
      din_q        <= din_d;
      wait_q       <= wait_d;
      ram_addr_q   <= ram_addr_d;
      ram_rd_q     <= ram_rd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      upload_q     <= ioctl_upload;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader: streaming, random access, back-to-back,
// bounds, abort and asynchronous reset, with a queue of expected bytes.
module tb_ioctl_upload_reader;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned SIZE    = 16;
  localparam int unsigned RAM_LAT = 2;

  logic              clk_sys      = 1'b0;
  logic              reset_n      = 1'b0;
  logic              ioctl_upload = 1'b0;
  logic              ioctl_rd     = 1'b0;
  logic [26:0]       ioctl_addr   = '0;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;
  logic              busy;
  logic              done;

  int compared   = 0;
  int mismatched = 0;
  int rd_count   = 0;
  logic [7:0] sb [$];
  logic [7:0] pipe [RAM_LAT];

  ioctl_upload_reader #(
    .ADDR_W (ADDR_W),
    .SIZE   (SIZE),
    .RAM_LAT(RAM_LAT)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .ram_addr    (ram_addr),
    .ram_rd      (ram_rd),
    .ram_q       (ram_q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM model: byte n holds n; idle cycles push 8'hEE so mistimed captures are visible.
  always @(posedge clk_sys) begin
    pipe[0] <= ram_rd ? 8'(ram_addr) : 8'hEE;
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
    if (ram_rd) rd_count <= rd_count + 1;
  end
  assign ram_q = pipe[RAM_LAT-1];

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_byte(input logic [26:0] a);
    return (a >= 27'(SIZE)) ? 8'hFF : a[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe one read (entered just after a negedge), then wait for ioctl_din.
  task automatic do_read(input logic [26:0] a, input int exp_wait, input string tag);
    int wc = 0;
    sb.push_back(exp_byte(a));
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    while (ioctl_wait === 1'b1 && wc < 40) begin
      wc++;
      @(negedge clk_sys);
    end
    check({tag, " wait"}, wc, exp_wait);
    check({tag, " din"}, ioctl_din, sb.pop_front());
  endtask

  initial begin
    int wc;
    int base;

    // Reset values
    repeat (2) @(negedge clk_sys);
    check("rst din", ioctl_din, 8'h00);
    check("rst wait", ioctl_wait, 1'b0);
    check("rst ram_addr", ram_addr, '0);
    check("rst ram_rd", ram_rd, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Session start prefetches address 0
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("start busy", busy, 1'b1);
    check("start ram_rd", ram_rd, 1'b1);
    check("start ram_addr", ram_addr, 5'd0);
    repeat (RAM_LAT + 1) @(negedge clk_sys);

    // Sequential stream, strobes RAM_LAT+2 cycles apart, all hits
    base = rd_count;
    for (int a = 0; a < int'(SIZE); a++) begin
      do_read(27'(a), 0, $sformatf("stream%0d", a));
      if (a < int'(SIZE) - 1) repeat (RAM_LAT + 1) @(negedge clk_sys);
    end
    repeat (2) @(negedge clk_sys);
    check("stream ram_rd count", rd_count - base, SIZE - 1);

    // Bounds: no RAM access for out-of-range reads
    base = rd_count;
    do_read(27'd16, 0, "oob16");
    do_read(27'h7FFFFFF, 0, "oobmax");
    @(negedge clk_sys);
    check("oob ram_rd count", rd_count - base, 0);
    do_read(27'd15, RAM_LAT + 1, "miss15");
    repeat (2) @(negedge clk_sys);
    check("miss15 ram_rd count", rd_count - base, 1);

    // Random access
    do_read(27'd3, RAM_LAT + 1, "ra3");
    repeat (RAM_LAT + 1) @(negedge clk_sys);
    do_read(27'd9, RAM_LAT + 1, "ra9");
    repeat (RAM_LAT + 1) @(negedge clk_sys);
    do_read(27'd10, 0, "ra10hit");
    repeat (RAM_LAT + 1) @(negedge clk_sys);

    // Abort during FETCH
    ioctl_rd   = 1'b1;
    ioctl_addr = 27'd5;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("abort wait before", ioctl_wait, 1'b1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("abort done", done, 1'b1);
    check("abort wait", ioctl_wait, 1'b0);
    check("abort din held", ioctl_din, 8'h0A);
    @(negedge clk_sys);
    check("abort done once", done, 1'b0);
    check("abort busy", busy, 1'b0);
    repeat (RAM_LAT + 2) @(negedge clk_sys);
    check("abort late ram_q ignored", ioctl_din, 8'h0A);

    // New session prefetches address 0
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("restart ram_rd", ram_rd, 1'b1);
    check("restart ram_addr", ram_addr, 5'd0);
    check("restart busy", busy, 1'b1);
    repeat (RAM_LAT + 1) @(negedge clk_sys);

    // Back-to-back: addr 1 lands while its prefetch is in flight
    sb.push_back(exp_byte(27'd0));
    sb.push_back(exp_byte(27'd1));
    ioctl_rd   = 1'b1;
    ioctl_addr = 27'd0;
    @(negedge clk_sys);
    ioctl_addr = 27'd1;
    check("b2b din0", ioctl_din, sb.pop_front());
    check("b2b wait0", ioctl_wait, 1'b0);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    wc = 0;
    while (ioctl_wait === 1'b1 && wc < 40) begin
      wc++;
      @(negedge clk_sys);
    end
    check("b2b pending wait", wc, RAM_LAT);
    check("b2b din1", ioctl_din, sb.pop_front());
    repeat (RAM_LAT + 1) @(negedge clk_sys);

    // Asynchronous reset in the middle of a miss
    ioctl_rd   = 1'b1;
    ioctl_addr = 27'd12;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check("arst pre wait", ioctl_wait, 1'b1);
    check("arst pre ram_rd", ram_rd, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst wait", ioctl_wait, 1'b0);
    check("arst busy", busy, 1'b0);
    check("arst ram_rd", ram_rd, 1'b0);
    check("arst din", ioctl_din, 8'h00);
    @(negedge clk_sys);
    reset_n = 1'b1;
    base = rd_count;
    repeat (RAM_LAT + 3) @(negedge clk_sys);
    check("arst no restart busy", busy, 1'b0);
    check("arst no restart ram_rd", rd_count - base, 0);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("arst new session busy", busy, 1'b1);
    check("arst new session ram_rd", ram_rd, 1'b1);
    repeat (RAM_LAT + 1) @(negedge clk_sys);
    do_read(27'd0, 0, "arst rd0");
    ioctl_upload = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("end busy", busy, 1'b0);
    check("queue drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
